// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with enable, load, clear, terminal count and wrap/saturate modes.
// Revision: 1.0
`default_nettype none

module modn_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS must lie in 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic at_end;

  // End detection happens before stepping, so count never leaves 0..MODULUS-1
  assign at_end = up_dn ? (count == MAX_CNT) : (count == '0);
  assign tc     = en & at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (load) begin
      count <= (load_val > MAX_CNT) ? MAX_CNT : load_val;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else if (en) begin
      wrap <= 1'b0;
      sat  <= 1'b0;
      if (at_end) begin
        if (SATURATE != 0) begin
          sat <= 1'b1;
        end else begin
          count <= up_dn ? '0 : MAX_CNT;
          wrap  <= 1'b1;
        end
      end else begin
        count <= up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench: three counter configurations against an arithmetic reference model.
`default_nettype none

module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] cnt_a, cnt_s;
  logic [2:0] cnt_f;
  logic       tc_a, tc_s, tc_f, wrap_a, wrap_s, wrap_f, sat_a, sat_s, sat_f;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count(cnt_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s));

  modn_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_f (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val[2:0]), .count(cnt_f), .tc(tc_f), .wrap(wrap_f), .sat(sat_f));

  // Reference model: plain integer arithmetic, out-of-range detected after the step
  typedef struct packed {
    int cnt;
    bit wrp;
    bit st;
  } mstate_t;

  mstate_t ma = '0, ms = '0, mf = '0;

  function automatic mstate_t step(mstate_t s, int m, bit satm, bit e, bit u, bit c,
                                   bit l, int lv);
    mstate_t n = s;
    int t;
    n.wrp = 1'b0;
    if (c) begin
      n.cnt = 0; n.st = 1'b0;
    end else if (l) begin
      n.cnt = (lv < m) ? lv : m - 1; n.st = 1'b0;
    end else if (e) begin
      t = u ? s.cnt + 1 : s.cnt - 1;
      if (t < 0 || t >= m) begin
        if (satm) n.st = 1'b1;
        else begin
          n.cnt = (t + m) % m; n.wrp = 1'b1;
        end
      end else begin
        n.cnt = t; n.st = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic bit model_tc(int c, int m);
    return en && (up_dn ? (c == m - 1) : (c == 0));
  endfunction

  always @(negedge rst) begin
    ma = '0; ms = '0; mf = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      ma = step(ma, 10, 1'b0, en, up_dn, clear, load, int'(load_val));
      ms = step(ms, 10, 1'b1, en, up_dn, clear, load, int'(load_val));
      mf = step(mf, 8,  1'b0, en, up_dn, clear, load, int'(load_val[2:0]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("a.count", 32'(cnt_a), ma.cnt);
    chk("a.tc",    32'(tc_a),  32'(model_tc(ma.cnt, 10)));
    chk("a.wrap",  32'(wrap_a), 32'(ma.wrp));
    chk("a.sat",   32'(sat_a),  32'(ma.st));
    chk("s.count", 32'(cnt_s), ms.cnt);
    chk("s.tc",    32'(tc_s),  32'(model_tc(ms.cnt, 10)));
    chk("s.wrap",  32'(wrap_s), 32'(ms.wrp));
    chk("s.sat",   32'(sat_s),  32'(ms.st));
    chk("f.count", 32'(cnt_f), mf.cnt);
    chk("f.tc",    32'(tc_f),  32'(model_tc(mf.cnt, 8)));
    chk("f.wrap",  32'(wrap_f), 32'(mf.wrp));
    chk("f.sat",   32'(sat_f),  32'(mf.st));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // {en, up_dn, clear, load, load_val}
  logic [7:0] vec [16] = '{
    8'hC0, 8'hC0, 8'h80, 8'h80, 8'h80, 8'hC0, 8'h00, 8'h9F,
    8'h80, 8'h80, 8'hA0, 8'h80, 8'h41, 8'hC0, 8'h90, 8'hD3};

  initial begin
    // Reset state
    #1;
    chk("rst.count", 32'(cnt_a), 0);
    chk("rst.wrap",  32'(wrap_a), 0);
    chk("rst.tc_up", 32'(tc_a), 0);
    cyc(); cyc();
    rst = 1'b1;

    // T2: wrap up
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 9) begin
        chk("t2.cnt9", 32'(cnt_a), 9);
        chk("t2.tc9",  32'(tc_a), 1);
      end
      if (i == 10) begin
        chk("t2.cnt0",  32'(cnt_a), 0);
        chk("t2.wrap",  32'(wrap_a), 1);
        chk("t2.s_hold", 32'(cnt_s), 9);
        chk("t2.s_sat", 32'(sat_s), 1);
      end
      if (i == 11) chk("t2.wrap_off", 32'(wrap_a), 0);
    end
    chk("t2.f_cnt", 32'(cnt_f), 4);

    // T1: asynchronous reset mid-count at 7
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0;
    chk("t1.pre7", 32'(cnt_a), 7);
    rst = 1'b0;
    #1;
    chk("t1.async_cnt", 32'(cnt_a), 0);
    chk("t1.async_wrap", 32'(wrap_a), 0);
    chk("t1.async_sat", 32'(sat_s), 0);
    up_dn = 1'b0; en = 1'b1;
    #1;
    chk("t1.tc_down", 32'(tc_a), 1);
    en = 1'b0; up_dn = 1'b1;
    cyc(); cyc();
    rst = 1'b1;
    en = 1'b1;
    cyc();
    chk("t1.first_up", 32'(cnt_a), 1);

    // T3: wrap down from 2
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    cyc();
    load = 1'b0; up_dn = 1'b0; en = 1'b1;
    cyc(); chk("t3.c1", 32'(cnt_a), 1);
    cyc(); chk("t3.c0", 32'(cnt_a), 0); chk("t3.tc0", 32'(tc_a), 1);
    cyc(); chk("t3.c9", 32'(cnt_a), 9); chk("t3.wrap", 32'(wrap_a), 1);
    cyc(); chk("t3.c8", 32'(cnt_a), 8); chk("t3.wrap_off", 32'(wrap_a), 0);

    // T4: load clamp and priority
    en = 1'b0; load = 1'b1; load_val = 4'd13;
    cyc(); chk("t4.clamp", 32'(cnt_a), 9);
    clear = 1'b1;
    cyc(); chk("t4.clear_wins", 32'(cnt_a), 0);
    clear = 1'b0; en = 1'b1; up_dn = 1'b1; load_val = 4'd4;
    cyc(); chk("t4.load_wins", 32'(cnt_a), 4);
    load = 1'b0; en = 1'b0;

    // T5: saturate from 7
    load = 1'b1; load_val = 4'd7;
    cyc();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    cyc(); chk("t5.c8", 32'(cnt_s), 8);
    cyc(); chk("t5.c9", 32'(cnt_s), 9); chk("t5.sat0", 32'(sat_s), 0);
    cyc(); chk("t5.hold", 32'(cnt_s), 9); chk("t5.sat1", 32'(sat_s), 1);
    cyc(); cyc();
    chk("t5.hold2", 32'(cnt_s), 9); chk("t5.nowrap", 32'(wrap_s), 0);
    up_dn = 1'b0;
    cyc(); chk("t5.back8", 32'(cnt_s), 8); chk("t5.sat_clr", 32'(sat_s), 0);
    en = 1'b0;

    // T6: full-range 3-bit counter
    clear = 1'b1;
    cyc();
    clear = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (20) cyc();
    chk("t6.cnt20", 32'(cnt_f), 4);
    en = 1'b0;
    repeat (3) cyc();
    chk("t6.hold", 32'(cnt_f), 4);
    chk("t6.tc_off", 32'(tc_f), 0);

    // Mixed directed vectors, checked by the model every cycle
    for (int i = 0; i < 16; i++) begin
      {en, up_dn, clear, load, load_val} = vec[i];
      cyc();
    end
    en = 1'b0; clear = 1'b0; load = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
